// File: rtl/pd_pkg.sv
// Shared defaults, sample/power types and the saturating adder for pd_power_accum.
package pd_pkg;

  localparam int PD_DW     = 16;
  localparam int PD_CH_NUM = 80;
  localparam int PD_CHW    = 7;
  localparam int PD_ACC_W  = 64;
  localparam int PD_LEN_W  = 16;

  // Widest accumulator sat_add can serve; instances must keep ACC_W <= SAT_W.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [PD_DW-1:0] i;
    logic signed [PD_DW-1:0] q;
  } iq_sample_t;

  typedef logic [2*PD_DW-1:0] pwr_t;

  // acc + p clamped to 2^acc_w-1; sat reports that the clamp was applied.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] p,
                                               input int unsigned      acc_w,
                                               output logic            sat);
    logic [SAT_W:0] raw;
    logic [SAT_W:0] lim;
    raw = {1'b0, acc} + {1'b0, p};
    lim = ((SAT_W+1)'(1) << acc_w) - (SAT_W+1)'(1);
    sat = (raw > lim);
    return sat ? lim[SAT_W-1:0] : raw[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/pd_power_accum_if.sv
// Sample-in / result-out bundle of pd_power_accum.
// master: sample source and result consumer; slave: the accumulator.
interface pd_power_accum_if import pd_pkg::*; #(
  parameter int DW    = PD_DW,
  parameter int CHW   = PD_CHW,
  parameter int ACC_W = PD_ACC_W
);
  logic              i_valid;
  logic [2*DW-1:0]   i_data;
  logic [CHW-1:0]    i_ch;
  logic              o_valid;
  logic [CHW-1:0]    o_ch;
  logic [ACC_W-1:0]  o_power;
  logic              o_sat;
  logic              o_err;
  logic [2*DW-1:0]   o_peak;

  modport master (
    output i_valid, i_data, i_ch,
    input  o_valid, o_ch, o_power, o_sat, o_err, o_peak
  );

  modport slave (
    input  i_valid, i_data, i_ch,
    output o_valid, o_ch, o_power, o_sat, o_err, o_peak
  );
endinterface

// File: rtl/pd_iq_square.sv
// S1-S2 of the power accumulator: register I/Q/ch, then I*I+Q*Q registered with ch/valid.
// Latency 2 for power, 1 for err; no backpressure, every strobe is taken.
module pd_iq_square import pd_pkg::*; #(
  parameter int DW     = PD_DW,
  parameter int CH_NUM = PD_CH_NUM,
  parameter int CHW    = PD_CHW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  input  logic [2*DW-1:0] in_dat,
  input  logic [CHW-1:0]  in_ch,
  output logic            out_vld,
  output logic [2*DW-1:0] out_pwr,
  output logic [CHW-1:0]  out_ch,
  output logic            out_err
);

  logic                   s1_vld_q, s1_vld_d;
  logic signed [DW-1:0]   s1_i_q, s1_i_d;
  logic signed [DW-1:0]   s1_q_q, s1_q_d;
  logic [CHW-1:0]         s1_ch_q, s1_ch_d;
  logic                   err_q, err_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [2*DW-1:0]        s2_pwr_q, s2_pwr_d;
  logic [CHW-1:0]         s2_ch_q, s2_ch_d;
  logic                   in_range;
  logic signed [2*DW-1:0] i_ext, q_ext, i_sq, q_sq;

  always_comb begin
    in_range = (int'(in_ch) < CH_NUM);
    s1_vld_d = in_vld && in_range;
    err_d    = in_vld && !in_range;
    s1_i_d   = in_dat[2*DW-1:DW];
    s1_q_d   = in_dat[DW-1:0];
    s1_ch_d  = in_ch;

    // Squares are non-negative; even (-2^(DW-1))^2 * 2 = 2^(2DW-1) fits unsigned.
    i_ext    = (2*DW)'(s1_i_q);
    q_ext    = (2*DW)'(s1_q_q);
    i_sq     = i_ext * i_ext;
    q_sq     = q_ext * q_ext;
    s2_pwr_d = $unsigned(i_sq) + $unsigned(q_sq);
    s2_vld_d = s1_vld_q;
    s2_ch_d  = s1_ch_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_i_q   <= '0;
      s1_q_q   <= '0;
      s1_ch_q  <= '0;
      err_q    <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_pwr_q <= '0;
      s2_ch_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_i_q   <= s1_i_d;
      s1_q_q   <= s1_q_d;
      s1_ch_q  <= s1_ch_d;
      err_q    <= err_d;
      s2_vld_q <= s2_vld_d;
      s2_pwr_q <= s2_pwr_d;
      s2_ch_q  <= s2_ch_d;
    end
  end

  assign out_vld = s2_vld_q;
  assign out_pwr = s2_pwr_q;
  assign out_ch  = s2_ch_q;
  assign out_err = err_q;

endmodule

// File: rtl/pd_power_accum.sv
// Multi-channel I^2+Q^2 window accumulator: latency 3 sample->o_valid, no backpressure.
// S3 is a one-cycle RMW per channel; define PD_PEAK_EN to add the per-window peak on o_peak.
module pd_power_accum import pd_pkg::*; #(
  parameter int DW     = PD_DW,
  parameter int CH_NUM = PD_CH_NUM,
  parameter int CHW    = PD_CHW,
  parameter int ACC_W  = PD_ACC_W,
  parameter int LEN_W  = PD_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  pd_power_accum_if.slave   bus,
  input  logic [LEN_W-1:0]  cfg_acc_len,
  input  logic              i_clr,
  input  logic [CHW-1:0]    i_clr_ch,
  input  logic              i_clr_all
);

  logic              s2_vld;
  logic [2*DW-1:0]   s2_pwr;
  logic [CHW-1:0]    s2_ch;
  logic              sq_err;

  pd_iq_square #(.DW(DW), .CH_NUM(CH_NUM), .CHW(CHW)) u_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (bus.i_valid),
    .in_dat  (bus.i_data),
    .in_ch   (bus.i_ch),
    .out_vld (s2_vld),
    .out_pwr (s2_pwr),
    .out_ch  (s2_ch),
    .out_err (sq_err)
  );

  logic [ACC_W-1:0] acc_q [CH_NUM];
  logic [ACC_W-1:0] acc_d [CH_NUM];
  logic [LEN_W-1:0] cnt_q [CH_NUM];
  logic [LEN_W-1:0] cnt_d [CH_NUM];
  logic             sat_q [CH_NUM];
  logic             sat_d [CH_NUM];

  logic             o_valid_q, o_valid_d;
  logic [CHW-1:0]   o_ch_q, o_ch_d;
  logic [ACC_W-1:0] o_power_q, o_power_d;
  logic             o_sat_q, o_sat_d;

  logic [CH_NUM-1:0] clr_vec;
  logic              hit_clr;
  logic              upd;
  logic              dump;
  logic              add_sat;
  logic [ACC_W-1:0]  sum;
  logic [LEN_W-1:0]  n;
  logic [LEN_W-1:0]  len_eff;

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      clr_vec[c] = i_clr_all || (i_clr && (int'(i_clr_ch) == c));
    end
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    o_valid_d = 1'b0;
    o_ch_d    = o_ch_q;
    o_power_d = o_power_q;
    o_sat_d   = o_sat_q;

    add_sat = 1'b0;
    sum     = ACC_W'(sat_add(SAT_W'(acc_q[s2_ch]), SAT_W'(s2_pwr), ACC_W, add_sat));
    n       = cnt_q[s2_ch] + LEN_W'(1);
    len_eff = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;
    // Live cfg compare: shrinking the window mid-way dumps on the next sample.
    dump    = (n >= len_eff);
    hit_clr = clr_vec[s2_ch];
    upd     = s2_vld && !hit_clr;

    if (upd) begin
      if (dump) begin
        o_valid_d     = 1'b1;
        o_ch_d        = s2_ch;
        o_power_d     = sum;
        o_sat_d       = sat_q[s2_ch] | add_sat;
        acc_d[s2_ch]  = '0;
        cnt_d[s2_ch]  = '0;
        sat_d[s2_ch]  = 1'b0;
      end else begin
        acc_d[s2_ch]  = sum;
        cnt_d[s2_ch]  = n;
        sat_d[s2_ch]  = sat_q[s2_ch] | add_sat;
      end
    end

    // Clears land after the S3 update so a clear aimed at the S3 channel wins.
    for (int c = 0; c < CH_NUM; c++) begin
      if (clr_vec[c]) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
        sat_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        sat_q[c] <= 1'b0;
      end
      o_valid_q <= 1'b0;
      o_ch_q    <= '0;
      o_power_q <= '0;
      o_sat_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      o_valid_q <= o_valid_d;
      o_ch_q    <= o_ch_d;
      o_power_q <= o_power_d;
      o_sat_q   <= o_sat_d;
    end
  end

`ifdef PD_PEAK_EN
  logic [2*DW-1:0] peak_q [CH_NUM];
  logic [2*DW-1:0] peak_d [CH_NUM];
  logic [2*DW-1:0] o_peak_q, o_peak_d;
  logic [2*DW-1:0] peak_new;

  always_comb begin
    peak_d   = peak_q;
    o_peak_d = o_peak_q;
    peak_new = (s2_pwr > peak_q[s2_ch]) ? s2_pwr : peak_q[s2_ch];
    if (upd) begin
      if (dump) begin
        o_peak_d      = peak_new;
        peak_d[s2_ch] = '0;
      end else begin
        peak_d[s2_ch] = peak_new;
      end
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (clr_vec[c]) peak_d[c] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) peak_q[c] <= '0;
      o_peak_q <= '0;
    end else begin
      peak_q   <= peak_d;
      o_peak_q <= o_peak_d;
    end
  end

  assign bus.o_peak = o_peak_q;
`else
  assign bus.o_peak = '0;
`endif

  assign bus.o_valid = o_valid_q;
  assign bus.o_ch    = o_ch_q;
  assign bus.o_power = o_power_q;
  assign bus.o_sat   = o_sat_q;
  assign bus.o_err   = sq_err;

endmodule

// File: tb/tb_pd_power_accum.sv
// Bench for pd_power_accum: directed scenarios plus random traffic against a window-level model.
// ACC_W is reduced to 34 so saturation is reachable in a few samples.
module tb_pd_power_accum;
  import pd_pkg::*;

  localparam int DW     = PD_DW;
  localparam int CH_NUM = PD_CH_NUM;
  localparam int CHW    = PD_CHW;
  localparam int ACC_W  = 34;
  localparam int LEN_W  = PD_LEN_W;
  localparam longint MAXV = (longint'(1) <<< ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [LEN_W-1:0] cfg_acc_len;
  logic             i_clr;
  logic [CHW-1:0]   i_clr_ch;
  logic             i_clr_all;

  int checks = 0;
  int failures = 0;
  int tcfg = 1;

  pd_power_accum_if #(.DW(DW), .CHW(CHW), .ACC_W(ACC_W)) bus ();

  pd_power_accum #(.DW(DW), .CH_NUM(CH_NUM), .CHW(CHW), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cfg_acc_len (cfg_acc_len),
    .i_clr       (i_clr),
    .i_clr_ch    (i_clr_ch),
    .i_clr_all   (i_clr_all)
  );

  always #5 clk = ~clk;

  // Reference state: per-channel window contents plus the two samples still in flight.
  longint m_acc  [CH_NUM];
  int     m_cnt  [CH_NUM];
  bit     m_sat  [CH_NUM];
  longint m_peak [CH_NUM];
  bit     p1_v, p2_v;
  int     p1_ch, p2_ch;
  longint p1_p, p2_p;
  bit     e_vld, e_err, e_sat;
  int     e_ch;
  longint e_pow, e_peak;
  int     n_vld = 0;
  longint last_pow = 0, last_peak = 0;
  int     last_ch = 0;
  bit     last_sat = 1'b0;
  int     cfg_tbl [7] = '{0, 1, 2, 3, 5, 8, 12};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH_NUM; c++) begin
      m_acc[c] = 0; m_cnt[c] = 0; m_sat[c] = 1'b0; m_peak[c] = 0;
    end
    p1_v = 1'b0; p2_v = 1'b0; p1_ch = 0; p2_ch = 0; p1_p = 0; p2_p = 0;
    e_vld = 1'b0; e_err = 1'b0; e_sat = 1'b0; e_ch = 0; e_pow = 0; e_peak = 0;
  endfunction

  // One clock of the reference: the sample driven two cycles ago meets this cycle's clears/cfg.
  function automatic void model_cycle(input bit v, input int ch, input int iv, input int qv,
                                      input bit clr, input int cch, input bit call);
    longint sum, pk;
    bit     satn;
    int     len;
    pwr_t   pv;
    e_err = v && (ch >= CH_NUM);
    e_vld = 1'b0;
    if (p2_v && !(call || (clr && cch == p2_ch))) begin
      sum  = m_acc[p2_ch] + p2_p;
      satn = m_sat[p2_ch];
      if (sum > MAXV) begin sum = MAXV; satn = 1'b1; end
      pk  = (p2_p > m_peak[p2_ch]) ? p2_p : m_peak[p2_ch];
      len = (tcfg == 0) ? 1 : tcfg;
      if (m_cnt[p2_ch] + 1 >= len) begin
        e_vld = 1'b1; e_ch = p2_ch; e_pow = sum; e_sat = satn;
`ifdef PD_PEAK_EN
        e_peak = pk;
`else
        e_peak = 0;
`endif
        m_acc[p2_ch] = 0; m_cnt[p2_ch] = 0; m_sat[p2_ch] = 1'b0; m_peak[p2_ch] = 0;
      end else begin
        m_acc[p2_ch] = sum; m_cnt[p2_ch]++; m_sat[p2_ch] = satn; m_peak[p2_ch] = pk;
      end
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (call || (clr && cch == c)) begin
        m_acc[c] = 0; m_cnt[c] = 0; m_sat[c] = 1'b0; m_peak[c] = 0;
      end
    end
    pv    = pwr_t'(longint'(iv) * iv + longint'(qv) * qv);
    p2_v  = p1_v; p2_ch = p1_ch; p2_p = p1_p;
    p1_v  = v && (ch < CH_NUM); p1_ch = ch; p1_p = longint'(pv);
  endfunction

  task automatic step(input bit v, input int ch, input int iv, input int qv,
                      input bit clr = 1'b0, input int cch = 0, input bit call = 1'b0);
    iq_sample_t s;
    @(negedge clk);
    chk("o_valid", 64'(bus.o_valid), 64'(e_vld));
    chk("o_err", 64'(bus.o_err), 64'(e_err));
    if (e_vld) begin
      chk("o_ch", 64'(bus.o_ch), 64'(e_ch));
      chk("o_power", 64'(bus.o_power), 64'(e_pow));
      chk("o_sat", 64'(bus.o_sat), 64'(e_sat));
      chk("o_peak", 64'(bus.o_peak), 64'(e_peak));
    end
    if (bus.o_valid) begin
      n_vld++;
      last_pow = longint'(bus.o_power); last_ch = int'(bus.o_ch);
      last_sat = bus.o_sat; last_peak = longint'(bus.o_peak);
    end
    s.i = 16'(iv);
    s.q = 16'(qv);
    bus.i_valid = v;
    bus.i_data  = s;
    bus.i_ch    = 7'(ch);
    cfg_acc_len = 16'(tcfg);
    i_clr       = clr;
    i_clr_ch    = 7'(cch);
    i_clr_all   = call;
    model_cycle(v, ch, iv, qv, clr, cch, call);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_valid = 1'b0; i_clr = 1'b0; i_clr_all = 1'b0;
    #1;
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_err", 64'(bus.o_err), 64'd0);
    chk("rst_o_sat", 64'(bus.o_sat), 64'd0);
    chk("rst_o_ch", 64'(bus.o_ch), 64'd0);
    chk("rst_o_power", 64'(bus.o_power), 64'd0);
    chk("rst_o_peak", 64'(bus.o_peak), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ch = '0;
    cfg_acc_len = '0; i_clr = 1'b0; i_clr_ch = '0; i_clr_all = 1'b0;
    do_reset();

    // Basic window of four p=25 samples.
    tcfg = 4;
    repeat (4) step(1'b1, 3, 3, 4);
    idle(4);
    chk("t1_power", 64'(last_pow), 64'd100);
    chk("t1_ch", 64'(last_ch), 64'd3);
    chk("t1_sat", 64'(last_sat), 64'd0);

    // Interleaved channels, dumps on consecutive cycles.
    tcfg = 2;
    repeat (2) begin
      step(1'b1, 0, 1, 0);
      step(1'b1, 1, 0, 2);
    end
    idle(4);
    chk("t2_power", 64'(last_pow), 64'd8);
    chk("t2_ch", 64'(last_ch), 64'd1);

    // Saturation, then a clean window on the same channel.
    tcfg = 8;
    repeat (8) step(1'b1, 5, -32768, -32768);
    idle(4);
    chk("t3_power", 64'(last_pow), 64'(MAXV));
    chk("t3_sat", 64'(last_sat), 64'd1);
    repeat (8) step(1'b1, 5, 0, 0);
    idle(4);
    chk("t3b_power", 64'(last_pow), 64'd0);
    chk("t3b_sat", 64'(last_sat), 64'd0);

    // Clear colliding with the S3 of the window-closing sample.
    tcfg = 3;
    n0 = n_vld;
    repeat (3) step(1'b1, 2, 3, 4);
    step(1'b0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 1'b1, 2);
    idle(3);
    chk("t4_no_dump", 64'(n_vld), 64'(n0));
    repeat (3) step(1'b1, 2, 4, 3);
    idle(4);
    chk("t4_power", 64'(last_pow), 64'd75);

    // Out-of-range channel and zero length.
    n0 = n_vld;
    step(1'b1, 90, 1, 1);
    idle(4);
    chk("t5_err_no_dump", 64'(n_vld), 64'(n0));
    tcfg = 0;
    step(1'b1, 4, 5, 0);
    step(1'b1, 4, 1, 1);
    step(1'b1, 4, 0, 7);
    idle(4);
    chk("t5_len0_count", 64'(n_vld - n0), 64'd3);
    chk("t5_len0_power", 64'(last_pow), 64'd49);

    // Reset mid-window discards the partial sum.
    tcfg = 4;
    repeat (2) step(1'b1, 7, 3, 4);
    idle(1);
    do_reset();
    repeat (4) step(1'b1, 7, 3, 4);
    idle(4);
    chk("t6_power", 64'(last_pow), 64'd100);
    step(1'b1, 7, 3, 4);
    step(1'b1, 7, 6, 8);
    step(1'b1, 7, 2, 0);
    step(1'b1, 7, 0, 3);
    idle(4);
    chk("t6b_power", 64'(last_pow), 64'd138);
`ifdef PD_PEAK_EN
    chk("t6b_peak", 64'(last_peak), 64'd100);
`else
    chk("t6b_peak", 64'(last_peak), 64'd0);
`endif

    // Random traffic: few channels, mixed magnitudes, occasional clears and cfg changes.
    for (int k = 0; k < 1500; k++) begin
      bit v, clr, call;
      int ch, iv, qv, cch;
      if (k % 60 == 0) tcfg = cfg_tbl[$urandom_range(0, 6)];
      v  = ($urandom_range(0, 9) < 7);
      ch = ($urandom_range(0, 19) == 0) ? int'($urandom_range(80, 127)) : int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        iv = int'($urandom_range(0, 65535)) - 32768;
        qv = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        iv = int'($urandom_range(0, 40)) - 20;
        qv = int'($urandom_range(0, 40)) - 20;
      end
      clr  = ($urandom_range(0, 24) == 0);
      cch  = int'($urandom_range(0, 5));
      call = ($urandom_range(0, 149) == 0);
      step(v, ch, iv, qv, clr, cch, call);
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
